// File: rtl/sram_vec_reader_pkg.sv
// Shared state encoding for sram_vec_reader. The testbench imports this
// package as well.
package sram_vec_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sram_vec_reader_sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two.
// clear empties it synchronously; when empty, pop_data reads as zero.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  // a pop frees the slot this push lands in, so push at full is accepted then
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_vec_reader.sv
// Streams word_count SRAM words from base_addr into a vector stream, with
// credit-based read issue so the output FIFO can never overflow.
// Optional stall counter output enabled by `define VEC_READER_STALL_CNT_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing reads while words remain and credits allow
//   ST_DRAIN | all reads issued; waiting for returns and FIFO to empty
//   ST_FLUSH | aborted; discarding returns until none outstanding
module sram_vec_reader
  import sram_vec_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   word_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   tr_address,
  output logic [DATA_WIDTH/8-1:0] tr_byteenable,
  output logic                    tr_read,
  output logic                    tr_write,
  output logic [DATA_WIDTH-1:0]   tr_writedata,
  input  logic                    tr_waitrequest,
  input  logic [DATA_WIDTH-1:0]   tr_readdata,
  input  logic                    tr_readdataready,
  output logic [DATA_WIDTH-1:0]   vec_data,
  output logic                    vec_valid,
  input  logic                    vec_ready
`ifdef VEC_READER_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         credits;
  logic                  done_q;
  logic                  done_nxt;
  logic                  start_acc;
  logic                  issue;
  logic                  ret;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_clear;
  logic                  fifo_empty;

  // occupancy + outstanding never exceeds FIFO_DEPTH, so this cannot underflow
  assign credits    = CW'(FIFO_DEPTH) - (fifo_count + outstanding);
  assign tr_read    = (state == ST_FETCH) && (credits != '0);
  assign issue      = tr_read && !tr_waitrequest;
  assign ret        = tr_readdataready && (state != ST_IDLE) && (outstanding != '0);
  assign fifo_clear = (state == ST_FLUSH) ||
                      (abort && ((state == ST_FETCH) || (state == ST_DRAIN)));
  assign fifo_push  = ret && ((state == ST_FETCH) || (state == ST_DRAIN));
  assign vec_valid  = !fifo_empty && (state != ST_FLUSH);
  assign fifo_pop   = vec_valid && vec_ready;

  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign tr_address    = addr_q;
  assign tr_write      = 1'b0;
  assign tr_writedata  = '0;
  assign tr_byteenable = '1;

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (word_count != '0) state_nxt = ST_FETCH;
          else                  done_nxt  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (abort)                                        state_nxt = ST_FLUSH;
        else if (issue && (remaining == ADDR_WIDTH'(1)))  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort) state_nxt = ST_FLUSH;
        else if ((outstanding == '0) && fifo_empty) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (outstanding == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining   <= '0;
      outstanding <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (start_acc) begin
        addr_q    <= base_addr;
        remaining <= word_count;
      end else if (issue) begin
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef VEC_READER_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                         stall_cnt <= '0;
    else if (start_acc)                                   stall_cnt <= '0;
    else if (tr_read && tr_waitrequest && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (tr_readdata),
    .pop       (fifo_pop),
    .pop_data  (vec_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/sram_vec_reader.md
SRAM_VEC_READER -- requirements
Module: sram_vec_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, at least 2).
REQ-004 SHALL have port clock, input, 1, sole clock; one clock, no other clock domains.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports start, input, 1, single-cycle job request; and abort, input, 1, single-cycle cancel.
REQ-007 SHALL have ports base_addr, input, ADDR_WIDTH, first word address; and word_count, input, ADDR_WIDTH, number of words; both sampled on accepted start.
REQ-008 SHALL have ports busy, output, 1, job active; and done, output, 1, one-cycle job-complete pulse.
REQ-009 SHALL have ports tr_address, output, ADDR_WIDTH; tr_byteenable, output, DATA_WIDTH/8; tr_read, output, 1; tr_write, output, 1; tr_writedata, output, DATA_WIDTH; tr_waitrequest, input, 1 -- SRAM arbiter tr-side master.
REQ-010 SHALL have ports tr_readdata, input, DATA_WIDTH; and tr_readdataready, input, 1, read return strobe.
REQ-011 SHALL have ports vec_data, output, DATA_WIDTH; vec_valid, output, 1; vec_ready, input, 1 -- downstream vector stream.

Function
REQ-012 SHALL implement states IDLE, FETCH, DRAIN, FLUSH.
REQ-013 IDLE: start accepted -> latch base_addr, word_count; FETCH if word_count nonzero, else done pulse next cycle and stay IDLE.
REQ-014 start SHALL be ignored when not in IDLE.
REQ-015 FETCH: SHALL assert tr_read when credits = FIFO_DEPTH - (fifo occupancy + outstanding) > 0; a read is issued when tr_read && !tr_waitrequest.
REQ-016 Each issued read SHALL increment tr_address by 1 (modulo 2^ADDR_WIDTH, wraps to 0), decrement remaining, and increment outstanding.
REQ-017 tr_read, tr_address SHALL stay stable while tr_waitrequest is high.
REQ-018 Each tr_readdataready SHALL write tr_readdata into the FIFO and decrement outstanding; simultaneous issue and return SHALL leave outstanding unchanged.
REQ-019 remaining reaches 0 -> DRAIN; DRAIN -> IDLE with done pulse when outstanding = 0 and FIFO empty.
REQ-020 tr_write SHALL be 0, tr_writedata 0, tr_byteenable all ones at all times.
REQ-021 vec_valid SHALL equal FIFO not empty; word pops on vec_valid && vec_ready; FIFO push and pop in the same cycle SHALL be allowed at full and at empty (data still passes in order, no loss).
REQ-022 FIFO overflow SHALL be impossible by construction of the credit rule.
REQ-023 abort in FETCH/DRAIN -> FLUSH: stop issuing, discard returns, clear FIFO, vec_valid low; IDLE when outstanding = 0; no done pulse.
REQ-024 busy SHALL be high in FETCH, DRAIN, FLUSH.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, FIFO empty, outstanding 0, and set busy, done, tr_read, vec_valid to 0, tr_address to 0, and vec_data to 0.
REQ-026 Reset during FETCH SHALL drop tr_read immediately; a later tr_readdataready arriving in IDLE SHALL be ignored.

Configuration
REQ-027 With VEC_READER_STALL_CNT_EN defined, output stall_cnt (32 bits) SHALL count cycles in which tr_read && tr_waitrequest; it clears on accepted start and on reset and saturates at all ones.
REQ-028 Without VEC_READER_STALL_CNT_EN, the port and its counter SHALL be absent.

Structure
REQ-029 State encoding constants SHALL reside in shared package sram_vec_reader_pkg, which is reused by the bench.
REQ-030 The FIFO SHALL be sub-module sync_fifo (parameters DATA_WIDTH, DEPTH) with a count output.

Verification
REQ-031 base 0x00010, count 8, waitrequest 0, readdata latency 2, vec_ready 1 -> data from words 0x00010..0x00017 in order; done exactly once.
REQ-032 base 0xFFFFE, count 4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-033 vec_ready 0 for 20 cycles, count 10, FIFO_DEPTH 4 -> at most 4 reads outstanding plus buffered; no loss after vec_ready rises.
REQ-034 waitrequest high for 5 cycles on the 3rd read -> address held stable; stall_cnt = 5 with the macro defined.
REQ-035 abort with 2 reads outstanding -> FLUSH, returns discarded, vec_valid 0, IDLE with no done pulse.
REQ-036 word_count 0 -> no tr_read; done one cycle after start. Also: reset_n low mid-FETCH -> all outputs are at their reset values.
